impulse_accumulator: RTL and testbench
======================================

IMPULSE_ACCUMULATOR -- requirements
Module: impulse_accumulator

Interface
REQ-001 SHALL have parameter NUM_BODIES, default 8, meaning the number of OBB slots accumulated per frame.
REQ-002 SHALL have parameter ID_W, default $clog2(NUM_BODIES), meaning the body-index width.
REQ-003 SHALL have one clock and one reset: the clock is Clk; reset is Reset, asynchronous and active-high.
REQ-004 Clk  input  1  system clock; all state changes on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 frame_start  input  1  single-cycle pulse that ends accumulation and begins the drain.
REQ-007 in_valid  input  1  collision record present.
REQ-008 in_ready  output  1  record accepted when in_valid && in_ready.
REQ-009 in_id  input  ID_W  target body index.
REQ-010 in_impulse_x, in_impulse_y  input  24 each  signed linear impulse.
REQ-011 in_nudge_x, in_nudge_y  input  22 each  signed positional correction.
REQ-012 in_rot  input  11  signed rotational impulse.
REQ-013 out_valid  output  1  drained record present.
REQ-014 out_ready  input  1  consumer (OBB update stage) accepts the record.
REQ-015 out_id  output  ID_W  body index of the drained record.
REQ-016 out_impulse_x/y (24), out_nudge_x/y (22), out_rot (11)  output  signed  accumulated sums.
REQ-017 out_impulse_en  output  1  high when the slot received at least one record this frame.
REQ-018 out_last  output  1  high with the record for index NUM_BODIES-1.
REQ-019 busy  output  1  high while in the DRAIN state.

Function
REQ-020 SHALL implement a two-state FSM: ACCUM and DRAIN.
REQ-021 ACCUM behaviour:
- in_ready=1 and out_valid=0.
- Each accepted record adds its five fields into slot in_id.
- Sets that slot's hit flag.
- Accumulation is visible in the slot registers on the next cycle.
REQ-022 Every addition SHALL saturate to its field width: 24-bit fields to [-2^23, 2^23-1], 22-bit fields to [-2^21, 2^21-1], 11-bit field to [-1024, 1023]; there is no wrap-around.
REQ-023 An in_id >= NUM_BODIES SHALL be accepted and discarded without modifying any slot.
REQ-024 frame_start in ACCUM SHALL move the FSM to DRAIN on the next edge with the drain index = 0; a record accepted in the same cycle SHALL be included in the drain.
REQ-025 DRAIN outputs:
- in_ready=0 and out_valid=1.
- out_* show slot[drain index] combinationally from registers.
- out_impulse_en = hit flag.
REQ-026 DRAIN handshake: on out_valid && out_ready, the slot and its hit flag SHALL be cleared to zero and the index SHALL increment; outputs SHALL stay stable while out_ready=0.
REQ-027 The handshake at index NUM_BODIES-1 (out_last=1) SHALL return the FSM to ACCUM on the next edge.
REQ-028 frame_start during DRAIN SHALL be ignored.
REQ-029 Every slot, including those never hit, SHALL be emitted once per frame, in index order 0..NUM_BODIES-1.

Reset
REQ-030 Reset SHALL force state ACCUM, drain index 0, all slot sums 0 and all hit flags 0.
REQ-031 Output values while Reset is asserted: out_valid=0, out_last=0, busy=0, in_ready=1, all out_* data 0.
REQ-032 Reset mid-DRAIN SHALL abandon the drain and discard all accumulated values.

Structure
REQ-033 Package obb_pkg SHALL hold:
- Width constants: IMP_W=24, NUDGE_W=22, ROT_W=11.
- State enum acc_state_t {ACCUM, DRAIN}.
REQ-034 Sub-module sat_add (parameter W) SHALL perform signed saturating addition and be instantiated once per field.
REQ-035 Slot storage SHALL be flip-flop arrays; no RAM inference.

Verification
REQ-036 Basic drain: records (id 2, imp_x 100) and (id 2, imp_x -30), then frame_start -> drained id 2 shows imp_x 70 with en=1; all other ids show 0 with en=0; out_last on id 7.
REQ-037 Saturation: two records on id 0 with imp_y 0x7FFFF0 each -> out_impulse_y 0x7FFFFF; two with rot -1000 each -> out_rot -1024.
REQ-038 Backpressure: out_ready held 0 for 5 cycles at id 3 -> out_id stays 3 with stable data; in_ready stays 0.
REQ-039 Simultaneous events: in_valid (id 5, nudge_x 7) in the same cycle as frame_start -> drained id 5 shows nudge_x 7.
REQ-040 Reset at drain index 4 -> outputs go to reset values; a subsequent frame_start with no records drains all slots at 0 with en=0.
REQ-041 Out-of-range in_id 9 with NUM_BODIES=8 -> record accepted; all drained slots are 0.

Source files
------------

// File: rtl/impulse_accumulator_pkg.sv
// Shared widths, FSM state type and slot record for the impulse accumulator.
package obb_pkg;

  localparam int IMP_W   = 24;
  localparam int NUDGE_W = 22;
  localparam int ROT_W   = 11;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } acc_state_t;

  typedef struct packed {
    logic signed [IMP_W-1:0]   imp_x;
    logic signed [IMP_W-1:0]   imp_y;
    logic signed [NUDGE_W-1:0] nudge_x;
    logic signed [NUDGE_W-1:0] nudge_y;
    logic signed [ROT_W-1:0]   rot;
  } slot_t;

endpackage

// File: rtl/impulse_accumulator_sat_add.sv
// Signed saturating adder: clamps to the representable range instead of wrapping.
module sat_add #(
  parameter int W = 8
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);

  logic [W:0] sum;

  assign sum = {a[W-1], a} + {b[W-1], b};

  // Differing top two bits of the sign-extended sum means overflow.
  always_comb begin
    y = sum[W-1:0];
    if (sum[W] != sum[W-1]) begin
      y = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/impulse_accumulator.sv
// Per-body impulse accumulator: sums collision records per slot during a frame,
// then drains every slot in index order to the OBB update stage.
module impulse_accumulator
  import obb_pkg::*;
#(
  parameter int NUM_BODIES = 8,
  parameter int ID_W       = $clog2(NUM_BODIES)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      frame_start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ID_W-1:0]           in_id,
  input  logic signed [IMP_W-1:0]   in_impulse_x,
  input  logic signed [IMP_W-1:0]   in_impulse_y,
  input  logic signed [NUDGE_W-1:0] in_nudge_x,
  input  logic signed [NUDGE_W-1:0] in_nudge_y,
  input  logic signed [ROT_W-1:0]   in_rot,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ID_W-1:0]           out_id,
  output logic signed [IMP_W-1:0]   out_impulse_x,
  output logic signed [IMP_W-1:0]   out_impulse_y,
  output logic signed [NUDGE_W-1:0] out_nudge_x,
  output logic signed [NUDGE_W-1:0] out_nudge_y,
  output logic signed [ROT_W-1:0]   out_rot,
  output logic                      out_impulse_en,
  output logic                      out_last,
  output logic                      busy,
  output acc_state_t                dbg_state
);

  // Handshakes: input record transfers on in_valid && in_ready (ACCUM only);
  // drained record transfers on out_valid && out_ready (DRAIN only), and the
  // drained outputs hold steady while out_ready is low.

  localparam logic [ID_W:0]   NB      = (ID_W+1)'(NUM_BODIES);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_BODIES - 1);

  acc_state_t             state_q, state_d;
  logic [ID_W-1:0]        idx_q;
  slot_t                  slots [NUM_BODIES];
  logic [NUM_BODIES-1:0]  hit_q;

  slot_t                  cur;
  slot_t                  dsl;
  logic                   dhit;
  logic                   in_range;
  logic                   accept;
  logic                   drain_fire;
  logic                   at_last;

  logic signed [IMP_W-1:0]   s_ix, s_iy;
  logic signed [NUDGE_W-1:0] s_nx, s_ny;
  logic signed [ROT_W-1:0]   s_r;

  assign in_range   = {1'b0, in_id} < NB;
  assign accept     = (state_q == ACCUM) && in_valid && in_range;
  assign drain_fire = (state_q == DRAIN) && out_ready;
  assign at_last    = (idx_q == LAST_ID);
  assign dbg_state  = state_q;

  // Operand selection for the addressed slot and for the slot being drained.
  always_comb begin
    cur  = '0;
    dsl  = '0;
    dhit = 1'b0;
    for (int i = 0; i < NUM_BODIES; i++) begin
      if (in_id == ID_W'(i)) cur = slots[i];
      if (idx_q == ID_W'(i)) begin
        dsl  = slots[i];
        dhit = hit_q[i];
      end
    end
  end

  sat_add #(.W(IMP_W))   u_add_ix (.a(cur.imp_x),   .b(in_impulse_x), .y(s_ix));
  sat_add #(.W(IMP_W))   u_add_iy (.a(cur.imp_y),   .b(in_impulse_y), .y(s_iy));
  sat_add #(.W(NUDGE_W)) u_add_nx (.a(cur.nudge_x), .b(in_nudge_x),   .y(s_nx));
  sat_add #(.W(NUDGE_W)) u_add_ny (.a(cur.nudge_y), .b(in_nudge_y),   .y(s_ny));
  sat_add #(.W(ROT_W))   u_add_r  (.a(cur.rot),     .b(in_rot),       .y(s_r));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= ACCUM;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        if (frame_start) state_d = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready && at_last) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      idx_q <= '0;
    end else if (state_q == ACCUM) begin
      idx_q <= '0;
    end else if (out_ready) begin
      idx_q <= at_last ? '0 : idx_q + ID_W'(1);
    end
  end

  // Accepting and draining never overlap, so one slot write per cycle at most.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_BODIES; i++) slots[i] <= '0;
      hit_q <= '0;
    end else begin
      for (int i = 0; i < NUM_BODIES; i++) begin
        if (accept && in_id == ID_W'(i)) begin
          slots[i] <= '{imp_x: s_ix, imp_y: s_iy, nudge_x: s_nx, nudge_y: s_ny, rot: s_r};
          hit_q[i] <= 1'b1;
        end else if (drain_fire && idx_q == ID_W'(i)) begin
          slots[i] <= '0;
          hit_q[i] <= 1'b0;
        end
      end
    end
  end

  assign out_id         = out_valid ? idx_q : '0;
  assign out_impulse_x  = out_valid ? dsl.imp_x : '0;
  assign out_impulse_y  = out_valid ? dsl.imp_y : '0;
  assign out_nudge_x    = out_valid ? dsl.nudge_x : '0;
  assign out_nudge_y    = out_valid ? dsl.nudge_y : '0;
  assign out_rot        = out_valid ? dsl.rot : '0;
  assign out_impulse_en = out_valid && dhit;
  assign out_last       = out_valid && at_last;

endmodule

// File: tb/tb_impulse_accumulator.sv
// Randomized scoreboard bench for impulse_accumulator with directed corner frames.
module tb_impulse_accumulator;
  import obb_pkg::*;

  localparam int NB   = 8;
  localparam int IDW  = 4;
  localparam int RW   = IDW + 2 + 24 + 24 + 22 + 22 + 11;

  logic               Clk;
  logic               Reset;
  logic               frame_start;
  logic               in_valid;
  logic               in_ready;
  logic [IDW-1:0]     in_id;
  logic signed [23:0] in_impulse_x, in_impulse_y;
  logic signed [21:0] in_nudge_x, in_nudge_y;
  logic signed [10:0] in_rot;
  logic               out_valid;
  logic               out_ready;
  logic [IDW-1:0]     out_id;
  logic signed [23:0] out_impulse_x, out_impulse_y;
  logic signed [21:0] out_nudge_x, out_nudge_y;
  logic signed [10:0] out_rot;
  logic               out_impulse_en;
  logic               out_last;
  logic               busy;
  acc_state_t         dbg_state;

  impulse_accumulator #(.NUM_BODIES(NB), .ID_W(IDW)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
    .in_impulse_x(in_impulse_x), .in_impulse_y(in_impulse_y),
    .in_nudge_x(in_nudge_x), .in_nudge_y(in_nudge_y), .in_rot(in_rot),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_impulse_x(out_impulse_x), .out_impulse_y(out_impulse_y),
    .out_nudge_x(out_nudge_x), .out_nudge_y(out_nudge_y), .out_rot(out_rot),
    .out_impulse_en(out_impulse_en), .out_last(out_last), .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- scoreboard state ----------------
  logic [RW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  int m_ix[NB], m_iy[NB], m_nx[NB], m_ny[NB], m_r[NB];
  bit m_hit[NB];

  bit rdy_mode   = 1'b0;
  bit rdy_manual = 1'b0;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat(int v, int w);
    int lim = 1 << (w - 1);
    if (v > lim - 1) return lim - 1;
    if (v < -lim) return -lim;
    return v;
  endfunction

  function automatic logic [RW-1:0] pack_exp(int id, bit en, bit last,
                                             int ix, int iy, int nx, int ny, int r);
    return {4'(id), en, last, 24'(ix), 24'(iy), 22'(nx), 22'(ny), 11'(r)};
  endfunction

  function automatic logic [RW-1:0] pack_act();
    return {out_id, out_impulse_en, out_last, out_impulse_x, out_impulse_y,
            out_nudge_x, out_nudge_y, out_rot};
  endfunction

  function automatic void model_accept(int id, int ix, int iy, int nx, int ny, int r);
    if (id < NB) begin
      m_ix[id]  = sat(m_ix[id] + ix, 24);
      m_iy[id]  = sat(m_iy[id] + iy, 24);
      m_nx[id]  = sat(m_nx[id] + nx, 22);
      m_ny[id]  = sat(m_ny[id] + ny, 22);
      m_r[id]   = sat(m_r[id] + r, 11);
      m_hit[id] = 1'b1;
    end
  endfunction

  function automatic void model_frame();
    for (int i = 0; i < NB; i++) begin
      exp_q.push_back(pack_exp(i, m_hit[i], i == NB - 1,
                               m_ix[i], m_iy[i], m_nx[i], m_ny[i], m_r[i]));
      m_ix[i] = 0; m_iy[i] = 0; m_nx[i] = 0; m_ny[i] = 0; m_r[i] = 0;
      m_hit[i] = 1'b0;
    end
  endfunction

  function automatic int rnd_field(int w);
    int lim = 1 << (w - 1);
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 400)) - 200;
      1:       return lim - 1 - int'($urandom_range(0, 50));
      2:       return -lim + int'($urandom_range(0, 50));
      default: return int'($urandom_range(0, 2 * lim - 1)) - lim;
    endcase
  endfunction

  // ---------------- driver tasks (caller sits just after a rising edge) ----------------
  task automatic send(int id, int ix, int iy, int nx, int ny, int r, bit fs);
    in_valid     = 1'b1;
    in_id        = IDW'(id);
    in_impulse_x = 24'(ix);
    in_impulse_y = 24'(iy);
    in_nudge_x   = 22'(nx);
    in_nudge_y   = 22'(ny);
    in_rot       = 11'(r);
    frame_start  = fs;
    @(negedge Clk);
    check("in_ready_accum", in_ready, 1'b1);
    @(posedge Clk);
    model_accept(id, ix, iy, nx, ny, r);
    if (fs) model_frame();
    #1;
    in_valid    = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic frame_only();
    frame_start = 1'b1;
    @(posedge Clk);
    model_frame();
    #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(posedge Clk);
      #1;
      n++;
    end
    if (n >= 3000) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic step_ready();
    @(posedge Clk);
    rdy_manual = 1'b1;
    @(posedge Clk);
    rdy_manual = 1'b0;
  endtask

  task automatic check_reset_outputs(string name);
    check(name, {out_valid, out_last, busy, in_ready, pack_act()},
          {4'b0001, {RW{1'b0}}});
  endtask

  // ---------------- consumer ready driver ----------------
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge Clk);
      #1;
      out_ready = rdy_mode ? rdy_manual : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [RW-1:0] exp;
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        check("ready_busy_flags", {in_ready, busy}, {!out_valid, out_valid});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_drain: got id %0d expected no record", out_id);
          end else begin
            exp = exp_q.pop_front();
            check("drain_rec", pack_act(), exp);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [RW-1:0] snap;
    bit started;
    int nrec;

    Reset = 1'b1;
    frame_start = 1'b0;
    in_valid = 1'b0;
    in_id = '0;
    in_impulse_x = '0; in_impulse_y = '0;
    in_nudge_x = '0; in_nudge_y = '0; in_rot = '0;
    for (int i = 0; i < NB; i++) begin
      m_ix[i] = 0; m_iy[i] = 0; m_nx[i] = 0; m_ny[i] = 0; m_r[i] = 0; m_hit[i] = 1'b0;
    end

    repeat (3) @(posedge Clk);
    #1;
    check_reset_outputs("reset_outputs");
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;

    // Basic drain: two records into slot 2.
    send(2, 100, 0, 0, 0, 0, 1'b0);
    send(2, -30, 0, 0, 0, 0, 1'b0);
    frame_only();
    wait_drain();

    // Saturation on impulse_y and rot.
    send(0, 0, 24'h7FFFF0, 0, 0, 0, 1'b0);
    send(0, 0, 24'h7FFFF0, 0, 0, 0, 1'b0);
    send(0, 0, 0, 0, 0, -1000, 1'b0);
    send(0, 0, 0, 0, 0, -1000, 1'b0);
    frame_only();
    wait_drain();

    // Record in the same cycle as frame_start is included.
    send(5, 0, 0, 7, 0, 0, 1'b1);
    wait_drain();

    // Out-of-range ids are accepted and dropped.
    send(9, 1234, -55, 66, -77, 88, 1'b0);
    send(15, -1, 2, -3, 4, -5, 1'b0);
    frame_only();
    wait_drain();

    // Backpressure at index 3, with a frame_start pulse that must be ignored.
    send(3, rnd_field(24), rnd_field(24), rnd_field(22), rnd_field(22), rnd_field(11), 1'b0);
    send(1, rnd_field(24), rnd_field(24), rnd_field(22), rnd_field(22), rnd_field(11), 1'b0);
    rdy_mode = 1'b1;
    rdy_manual = 1'b0;
    frame_only();
    repeat (3) step_ready();
    @(negedge Clk);
    snap = pack_act();
    check("bp_id", out_id, 4'd3);
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      if (k == 1) frame_start = 1'b1;
      if (k == 2) frame_start = 1'b0;
      check("bp_hold", pack_act(), snap);
      check("bp_in_ready", in_ready, 1'b0);
    end
    frame_start = 1'b0;
    rdy_mode = 1'b0;
    wait_drain();

    // Reset in the middle of a drain at index 4.
    send(4, 500, 500, 500, 500, 500, 1'b0);
    send(6, -9, 9, -9, 9, -9, 1'b0);
    rdy_mode = 1'b1;
    rdy_manual = 1'b0;
    frame_only();
    repeat (4) step_ready();
    @(negedge Clk);
    check("pre_reset_id", out_id, 4'd4);
    #2;
    Reset = 1'b1;
    #1;
    check_reset_outputs("mid_drain_reset");
    exp_q.delete();
    @(negedge Clk);
    check_reset_outputs("held_reset");
    Reset = 1'b0;
    rdy_mode = 1'b0;
    @(posedge Clk);
    #1;
    frame_only();
    wait_drain();

    // Randomized frames.
    for (int f = 0; f < 8; f++) begin
      nrec = $urandom_range(0, 16);
      started = 1'b0;
      for (int r = 0; r < nrec; r++) begin
        send($urandom_range(0, 9), rnd_field(24), rnd_field(24), rnd_field(22),
             rnd_field(22), rnd_field(11), (r == nrec - 1) && ($urandom_range(0, 1) == 1));
        if (frame_start === 1'b0 && r == nrec - 1 && exp_q.size() != 0) started = 1'b1;
        repeat ($urandom_range(0, 2)) begin
          @(posedge Clk);
          #1;
        end
      end
      if (!started && !busy) frame_only();
      wait_drain();
    end

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
